s1_share_arb: RTL
=================

# s1_share_arb

Round-robin arbiter and sequencer that time-shares one registered 4:1 logic cell (mux plus output flip-flop) among NUM_REQ requesters. It issues one requester's operand to the cell, captures the registered result, and returns it tagged with the requester index. It sits between neuron-evaluation requesters and a single shared logic cell. The cell is instantiated outside this block and reached through the cell_* ports.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- ID_W, $clog2(NUM_REQ): requester index width.
- CNT_W, 16: width of completed-operation counter.

Ports:
- clk, input, 1: single clock, rising edge.
- clr, input, 1: reset, synchronous and active-high.
- req, input, NUM_REQ: per-requester request level.
- req_op, input, NUM_REQ*7: packed operands. Requester i occupies bits [7i+6:7i] as {d[3:0], a1, b1, a0}.
- grant, output, NUM_REQ: one-hot, single-cycle pulse marking operand acceptance.
- cell_d, output, 4: data inputs driven to shared cell.
- cell_a0, output, 1: select input A0 to cell.
- cell_a1, output, 1: select input A1 to cell.
- cell_b1, output, 1: select input B1 to cell.
- cell_out, input, 1: registered cell output.
- rsp_valid, output, 1: single-cycle result strobe.
- rsp_id, output, ID_W: index of requester owning the result.
- rsp_data, output, 1: captured cell result.
- busy, output, 1: high whenever state is not IDLE.
- ops_done, output, CNT_W: count of completed operations.

## Operation
- FSM states:
  - IDLE. If any req bit is set: arbitrate, latch winner index and operand, register grant, go to ISSUE. Otherwise stay.
  - ISSUE. Drive cell_* from the latched operand. Go to CAPTURE.
  - CAPTURE. Register rsp_data from cell_out, rsp_id from the latched winner, set rsp_valid, increment ops_done. Arbitrate in the same cycle: if any req is set, latch the new winner and operand, register grant, go to ISSUE. Otherwise go to IDLE.
- Arbitration is round-robin. The search starts at pointer ptr and wraps from NUM_REQ-1 to 0.
  - On each grant to index i, ptr becomes (i+1) mod NUM_REQ.
  - ptr resets to 0.
- Handshake rules:
  - A requester holds req and its operand stable until it sees its grant bit.
  - In the grant cycle the requester may drop req, or present a new operand to queue another operation.
  - req without grant never times out.
- cell_* outputs carry the latched operand only in ISSUE and are 0 in every other state.
- ops_done wraps from 2^CNT_W-1 to 0 with no flag.
- A req bit set during ISSUE is not sampled until CAPTURE.
- A requester whose result strobe and next grant fall in the same cycle receives both.

## Timing
- Reset values (clr high at an edge, takes priority over everything else):
  - state=IDLE, ptr=0.
  - grant=0, cell_*=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - busy=0, ops_done=0.
- Reset mid-operation: the in-flight operation is dropped, no rsp_valid is emitted, and ops_done is not incremented.
- Cell latency is fixed at 1 cycle: cell_out during CAPTURE reflects the operand driven during ISSUE.
- Latency: req sampled at edge E; grant high in cycle E+1 (ISSUE); rsp_valid high in cycle E+3. The request-to-result latency is 3 cycles.
- Throughput: one operation every 2 cycles under continuous request.
- grant, rsp_valid, rsp_id, rsp_data are all registered. No combinational path from req or cell_out to any output.

## Structure
- Package s1_share_pkg holds:
  - state enum {IDLE, ISSUE, CAPTURE};
  - OP_W=7;
  - operand struct {d[3:0], a1, b1, a0} and its field offsets.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req and ptr; outputs are any, winner index and one-hot.
- The FSM, operand/winner registers, response registers and counter are kept in s1_share_arb.

## Test plan
Benches use a behavioural cell model that sets out to d[{a1|b1, a0}] one cycle after its inputs.
- Single request: req=0001, op0 d=1010, a0=1, a1=0, b1=0 → grant=0001 one cycle later; rsp_valid 3 cycles after req with rsp_id=0, rsp_data=1; ops_done=1.
- Contention: req=0101 held, op2 d=0100, b1=1, a0=0 → grants alternate 0001, 0100, 0001, … every 2 cycles; rsp_data for id 2 = 1.
- Pointer wrap: grant to id 3 → next grant with req=1111 goes to id 0; ptr sequence is 0→1→2→3→0.
- Back-to-back: req=0001 held continuously → rsp_valid every 2 cycles; rsp_valid and the next grant coincide in the same cycle.
- Reset during ISSUE: clr asserted in ISSUE → next cycle all outputs at reset values, no rsp_valid, ops_done unchanged at 0.
- Counter wrap: with CNT_W=4, run 17 operations → ops_done reads 1.

Source files
------------

// File: rtl/s1_share_pkg.sv
// Shared types for the s1_share_arb logic-cell sequencer: FSM states and the
// 7-bit requester operand layout {d[3:0], a1, b1, a0}.
package s1_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam int OP_W       = 7;
    localparam int OP_A0_OFF  = 0;
    localparam int OP_B1_OFF  = 1;
    localparam int OP_A1_OFF  = 2;
    localparam int OP_D_OFF   = 3;

    typedef struct packed {
        logic [3:0] d;
        logic       a1;
        logic       b1;
        logic       a0;
    } op_t;

    function automatic op_t op_unpack(input logic [OP_W-1:0] raw);
        op_t op;
        op.d  = raw[OP_D_OFF +: 4];
        op.a1 = raw[OP_A1_OFF];
        op.b1 = raw[OP_B1_OFF];
        op.a0 = raw[OP_A0_OFF];
        return op;
    endfunction

endpackage

// File: rtl/s1_share_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    win,
    output logic [NUM_REQ-1:0] onehot
);

    // Rotating priority search starting at ptr.
    always_comb begin
        int              idx_v;
        logic [ID_W-1:0] cand_v;
        any    = 1'b0;
        win    = '0;
        onehot = '0;
        idx_v  = 0;
        cand_v = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = int'(ptr) + k;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            cand_v = ID_W'(idx_v);
            if (!any && req[cand_v]) begin
                any = 1'b1;
                win = cand_v;
            end else begin
                any = any;
            end
        end
        if (any) begin
            onehot[win] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/s1_share_arb.sv
// Time-shares one registered 4:1 logic cell among NUM_REQ requesters:
// grant, issue the operand for one cycle, capture the result tagged with its owner.
module s1_share_arb
    import s1_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [NUM_REQ-1:0]      grant,
    output logic [3:0]              cell_d,
    output logic                    cell_a0,
    output logic                    cell_a1,
    output logic                    cell_b1,
    input  logic                    cell_out,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_data,
    output logic                    busy,
    output logic [CNT_W-1:0]        ops_done
);

    state_e             state_r;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    win_r;
    logic [NUM_REQ-1:0] grant_r;
    op_t                cell_op_r;
    logic               rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic               rsp_data_r;
    logic               busy_r;
    logic [CNT_W-1:0]   ops_done_r;

    logic               pick_any_s;
    logic [ID_W-1:0]    pick_id_s;
    logic [NUM_REQ-1:0] pick_oh_s;
    logic [OP_W-1:0]    pick_raw_s;
    op_t                pick_op_s;
    logic [ID_W-1:0]    ptr_next_s;
    logic               arb_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .any    (pick_any_s),
        .win    (pick_id_s),
        .onehot (pick_oh_s)
    );

    // Winner operand select, next pointer, and whether this cycle may arbitrate.
    always_comb begin
        pick_raw_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id_s == ID_W'(i)) begin
                pick_raw_s = req_op[i*OP_W +: OP_W];
            end else begin
                pick_raw_s = pick_raw_s;
            end
        end
        pick_op_s = op_unpack(pick_raw_s);
        if (pick_id_s == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_id_s + ID_W'(1'b1);
        end
        if ((state_r == IDLE) || (state_r == CAPTURE)) begin
            arb_s = pick_any_s;
        end else begin
            arb_s = 1'b0;
        end
    end

    // FSM, grant/operand latch, response capture and completion counter.
    // ISSUE always lasts one cycle, so cell_op_r is loaded only on the grant edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            win_r       <= '0;
            grant_r     <= '0;
            cell_op_r   <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= 1'b0;
            busy_r      <= 1'b0;
            ops_done_r  <= '0;
        end else begin
            grant_r     <= '0;
            cell_op_r   <= '0;
            rsp_valid_r <= 1'b0;
            if (arb_s) begin
                ptr_r     <= ptr_next_s;
                win_r     <= pick_id_s;
                grant_r   <= pick_oh_s;
                cell_op_r <= pick_op_s;
            end
            case (state_r)
                IDLE: begin
                    state_r <= arb_s ? ISSUE : IDLE;
                    busy_r  <= arb_s;
                end
                ISSUE: begin
                    state_r <= CAPTURE;
                    busy_r  <= 1'b1;
                end
                CAPTURE: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= win_r;
                    rsp_data_r  <= cell_out;
                    ops_done_r  <= ops_done_r + CNT_W'(1'b1);
                    state_r     <= arb_s ? ISSUE : IDLE;
                    busy_r      <= arb_s;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign cell_d    = cell_op_r.d;
    assign cell_a0   = cell_op_r.a0;
    assign cell_a1   = cell_op_r.a1;
    assign cell_b1   = cell_op_r.b1;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;
    assign ops_done  = ops_done_r;

endmodule
